// File: rtl/neuron_accumulator.sv
// Sequential half of the neuron datapath: accumulates N_INPUTS signed products plus a
// bias per evaluation, then presents a ReLU-clipped 8-bit activation on valid/ready.
module neuron_accumulator #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned ACC_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_mul,
  input  logic [8:0] bias,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat
);

  localparam int unsigned IN_W  = 9;
  localparam int unsigned CNT_W = (N_INPUTS > 2) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] ACT_ZERO = '0;

  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic                     beat;
  logic signed [ACC_W-1:0]  mul_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;

  // Signed add clamped to the accumulator range on overflow.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] wide;
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sat_add = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_add = wide[ACC_W-1:0];
    end
  endfunction

  assign in_ready = (state_q == ACCUM);
  assign beat     = in_valid && in_ready;
  assign mul_ext  = {{(ACC_W-IN_W){in_mul[IN_W-1]}}, in_mul};
  assign bias_ext = {{(ACC_W-IN_W){bias[IN_W-1]}}, bias};
  // Bias enters only on the first beat, so mid-evaluation bias changes are inert.
  assign base     = (cnt_q == '0) ? bias_ext : acc_q;
  assign sum      = sat_add(base, mul_ext);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      ACCUM: begin
        if (beat) begin
          acc_d = sum;
          if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            state_d     = OUTPUT;
            out_valid_d = 1'b1;
            out_sat_d   = (sum > ACT_MAX);
            if (sum < ACT_ZERO) begin
              out_data_d = 8'd0;
            end else if (sum > ACT_MAX) begin
              out_data_d = 8'd127;
            end else begin
              out_data_d = sum[7:0];
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Scoreboard bench for neuron_accumulator: directed evaluations push expected
// activations; a negedge monitor checks every presented output against the queue.
module tb_neuron_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_mul;
  logic [8:0] bias;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  typedef struct packed {
    logic [7:0] data;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  neuron_accumulator #(.N_INPUTS(4), .ACC_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mul   (in_mul),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle an activation is presented, compare it to the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("in_ready_low_in_output", int'(in_ready), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d sat %0d with empty scoreboard",
                 out_data, out_sat);
      end else begin
        check("out_data", int'(out_data), int'(exp_q[0].data));
        check("out_sat", int'(out_sat), int'(exp_q[0].sat));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic expect_out(input int d, input bit s);
    exp_t e;
    e.data = 8'(d);
    e.sat  = s;
    exp_q.push_back(e);
  endtask

  task automatic send(input int m, input int b);
    in_valid = 1'b1;
    in_mul   = 9'(m);
    bias     = 9'(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending activations expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mul    = '0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_sat", int'(out_sat), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    idle(1);

    // 1: basic sum with latency and return-to-ACCUM checks
    expect_out(100, 1'b0);
    send(10, 0);
    send(20, 0);
    send(30, 0);
    send(40, 0);
    check("latency_out_valid", int'(out_valid), 1);
    idle(1);
    check("after_hs_out_valid", int'(out_valid), 0);
    check("after_hs_in_ready", int'(in_ready), 1);
    drain();

    // 2: negative clamp, then bias-only result
    expect_out(0, 1'b0);
    send(-50, -5); send(-50, -5); send(10, -5); send(10, -5);
    drain();
    expect_out(7, 1'b0);
    send(0, 7); send(0, 7); send(0, 7); send(0, 7);
    drain();

    // 3: positive saturation, then large negative sum
    expect_out(127, 1'b1);
    send(255, 100); send(255, 100); send(255, 100); send(255, 100);
    drain();
    expect_out(0, 1'b0);
    send(-256, -256); send(-256, -256); send(-256, -256); send(-256, -256);
    drain();

    // 4: backpressure with in_valid held high; ignored beats must not count
    out_ready = 1'b0;
    expect_out(23, 1'b0);
    send(5, 3); send(5, 3); send(5, 3); send(5, 3);
    in_valid = 1'b1;
    in_mul   = 9'(99);
    bias     = 9'(9);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("bp_out_valid_held", int'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_release_in_ready", int'(in_ready), 1);
    expect_out(19, 1'b0);
    send(1, 9); send(2, 9); send(3, 9); send(4, 9);
    drain();

    // 5: bubbles and a bias change after the first beat
    expect_out(16, 1'b0);
    send(1, 6);
    bias   = 9'(50);
    in_mul = 9'(77);
    idle(2);
    send(2, 50);
    in_mul = 9'(77);
    idle(1);
    send(3, 50);
    send(4, 50);
    drain();

    // 6: reset mid-evaluation discards the partial sum
    send(50, 0);
    send(50, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_sat", int'(out_sat), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_out(4, 1'b0);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    drain();

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Downstream consumer of the 8x8 signed fractional multiplier stage. Each multiplier output is a 9-bit signed product, equal to (weight*x)>>>7. This block accepts a stream of N_INPUTS such products per neuron evaluation, sums them with a bias, applies ReLU with saturation, and presents one 8-bit activation per evaluation on a valid/ready handshake. It forms the sequential half of the neuron datapath.

## Interface
- N_INPUTS, 4: products summed per evaluation; at least 2.
- ACC_W, 16: signed accumulator width; at least 12.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_mul carries a valid product.
- in_ready  out  1  block can accept a product; combinational, equals (state==ACCUM).
- in_mul  in  9  signed product from multiplier, same scale as bias.
- bias  in  9  signed bias; sampled on the first accepted beat of each evaluation.
- out_valid  out  1  out_data/out_sat hold a completed activation.
- out_ready  in  1  downstream accepts the activation.
- out_data  out  8  signed activation, range 0..127 only.
- out_sat  out  1  activation was clipped at 127.

## Operation
- States: ACCUM, OUTPUT. Reset state is ACCUM.
- Reset values: state=ACCUM, cnt=0, acc=0, out_valid=0, out_data=0, out_sat=0. in_ready reads 1 after reset.
- A beat is accepted when in_valid && in_ready. Cycles without a beat do not change cnt or acc.
- Accumulate rule for an accepted beat:
  - If cnt==0: acc_next = sext(bias) + sext(in_mul).
  - Otherwise: acc_next = acc + sext(in_mul).
  - Each addition saturates to the signed ACC_W range. This cannot trigger at the defaults but is required.
- cnt increments on each accepted beat and counts 0..N_INPUTS-1.
- Final beat (cnt==N_INPUTS-1 when accepted):
  - Compute sum = the acc_next value for that beat.
  - Register out_data = (sum<0) ? 0 : (sum>127 ? 127 : sum[7:0]).
  - Register out_sat = (sum>127).
  - Clear cnt to 0. Enter OUTPUT.
- OUTPUT state:
  - out_valid=1 and in_ready=0.
  - out_data and out_sat stay stable until the handshake.
  - Any in_valid is ignored.
- Handshake in OUTPUT: when out_ready=1 in OUTPUT, go to ACCUM. out_valid drops in the next cycle. out_data and out_sat keep their last values.
- Zero result: a sum of exactly 0 gives out_data=0 and out_sat=0.
- A bias change in mid-evaluation has no effect. The new value applies from the next evaluation's first beat.
- Reset mid-evaluation: assertion of rst_n immediately returns all state to reset values. A partial sum is discarded. The first beat accepted after reset release starts a new evaluation and re-samples bias.

## Timing
- in_ready is high in ACCUM, including the cycle of the final beat, so one beat per cycle is sustained.
- Latency: out_valid rises on the first clock edge after the final beat is accepted.
- OUTPUT lasts 1 cycle minimum (out_ready already high) and is unbounded under backpressure.
- No overlap between evaluations. Minimum period is N_INPUTS+1 cycles per activation.
- Outputs are registered. in_ready is the only combinational output and depends on state only, so there is no combinational path from in_valid or out_ready.

## Test plan
1. Basic sum:
   - Stimulus: bias=0; in_mul 10, 20, 30, 40 on consecutive cycles; out_ready=1.
   - Response: out_data=100, out_sat=0, out_valid one cycle after the 4th beat, then in_ready=1 on the following cycle.
2. Negative clamp and bias:
   - Stimulus: bias=-5; in_mul -50, -50, 10, 10 (sum -85).
   - Response: out_data=0, out_sat=0.
   - Second evaluation: bias=7; in_mul 0, 0, 0, 0. Response: out_data=7.
3. Saturation:
   - Stimulus: bias=100; in_mul 255 x4 (sum 1120).
   - Response: out_data=127, out_sat=1.
   - Then bias=-256; in_mul -256 x4. Response: out_data=0, out_sat=0.
4. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 throughout.
   - Response: out_data stays stable and in_ready=0; no beats are counted. After out_ready=1 the next 4 beats form a new evaluation that uses the current bias.
5. Bubbles:
   - Stimulus: in_valid pattern 1,0,0,1,0,1,1 carrying in_mul 1, x, x, 2, x, 3, 4, with bias changed after the first beat.
   - Response: out_data=10 plus the bias sampled at the first beat. The result is unaffected by the gaps.
6. Reset mid-evaluation:
   - Stimulus: accept 2 beats of 50, assert rst_n=0 for 1 cycle, release, then bias=0 and in_mul 1 x4.
   - Response: all outputs are at reset values during reset; the result is out_data=4.
